uart_tx_arbiter: RTL and testbench

Shares one 8N1 UART transmitter between `N_REQ` byte-stream requesters. Arbitration is round-robin at packet granularity: once a requester wins, it keeps the transmitter until its byte flagged `last` has fully left the line. The block sits between on-chip message sources (echo path, status reporter, debug dump) and the single `uart_tx` instance that drives the board's TX pin. It drives `uart_tx` through a `tx_start`/`tx_busy` handshake.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/rr_pick.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 159 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: 8N1 frame constants, the baud divisor helper and
// the state encoding of the transmit arbiter.
package uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_STOP_BITS  = 1;
  localparam int UART_FRAME_BITS = 1 + UART_DATA_BITS + UART_STOP_BITS;

  localparam int ARB_HOLD_W = 25;

  typedef enum logic [2:0] {
    ARB_IDLE      = 3'd0,
    ARB_SEND      = 3'd1,
    ARB_WAIT_BUSY = 3'd2,
    ARB_WAIT_DONE = 3'd3,
    ARB_GAP       = 3'd4
  } arb_state_t;

  // Rounded clocks per bit for a given core clock and baud rate.
  function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                               input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo N.
module rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         any
);

  logic [N-1:0] rot;
  logic [W-1:0] off;
  logic [W:0]   sum;

  always_comb begin
    // Rotate so the pointer position lands on bit 0, then priority-encode.
    rot = N'({req, req} >> ptr);
    off = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) off = W'(k);
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (W + 1)'(N)) sum = sum - (W + 1)'(N);
    idx = sum[W-1:0];
    any = |req;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one 8N1 uart_tx among N_REQ
// byte-stream sources via a tx_start/tx_busy handshake.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int GAP_CYCLES   = 0,
  parameter int HOLD_TIMEOUT = 25_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [7:0]         tx_data,
  output logic               tx_start,
  input  logic               tx_busy,
  output logic [2:0]         grant_id,
  output logic               grant_active,
  output logic               abort
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  arb_state_t            state_q, state_n;
  logic [IDX_W-1:0]      gid_q, gid_n;
  logic [IDX_W-1:0]      rr_q, rr_n;
  logic                  active_q, active_n;
  logic [7:0]            tx_data_q, tx_data_n;
  logic                  tx_start_q, tx_start_n;
  logic                  abort_q, abort_n;
  logic                  last_q, last_n;
  logic [ARB_HOLD_W-1:0] hold_q, hold_n;
  logic [GAP_W-1:0]      gap_q, gap_n;

  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             sel_valid;
  logic             sel_last;
  logic [7:0]       sel_data;
  logic [IDX_W-1:0] rr_after;
  logic             release_pkt;

  rr_pick #(.N(N_REQ), .W(IDX_W)) u_pick (
    .req (req_valid),
    .ptr (rr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign sel_valid = req_valid[gid_q];
  assign sel_last  = req_last[gid_q];
  assign sel_data  = req_data[{gid_q, 3'b000} +: 8];
  assign rr_after  = (gid_q == IDX_W'(N_REQ - 1)) ? '0 : gid_q + IDX_W'(1);

  // Only the owner can see ready, and only while the transmitter is free.
  always_comb begin
    req_ready = '0;
    if (!rst && state_q == ARB_SEND && !tx_busy) req_ready[gid_q] = sel_valid;
  end

  always_comb begin
    state_n     = state_q;
    gid_n       = gid_q;
    rr_n        = rr_q;
    active_n    = active_q;
    tx_data_n   = tx_data_q;
    tx_start_n  = 1'b0;
    abort_n     = 1'b0;
    last_n      = last_q;
    hold_n      = hold_q;
    gap_n       = gap_q;
    release_pkt = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          gid_n    = pick_idx;
          active_n = 1'b1;
          hold_n   = '0;
          state_n  = ARB_SEND;
        end
      end
      ARB_SEND: begin
        if (sel_valid) begin
          if (!tx_busy) begin
            tx_data_n  = sel_data;
            tx_start_n = 1'b1;
            last_n     = sel_last;
            hold_n     = '0;
            state_n    = ARB_WAIT_BUSY;
          end
        end else if (hold_q == ARB_HOLD_W'(HOLD_TIMEOUT - 1)) begin
          abort_n     = 1'b1;
          release_pkt = 1'b1;
        end else if (hold_q != '1) begin
          hold_n = hold_q + ARB_HOLD_W'(1);
        end
      end
      ARB_WAIT_BUSY: begin
        if (tx_busy) state_n = ARB_WAIT_DONE;
      end
      ARB_WAIT_DONE: begin
        if (!tx_busy) begin
          if (last_q) release_pkt = 1'b1;
          else        state_n     = ARB_SEND;
        end
      end
      ARB_GAP: begin
        if (gap_q == GAP_W'(GAP_CYCLES - 1)) state_n = ARB_IDLE;
        else                                 gap_n   = gap_q + GAP_W'(1);
      end
      default: state_n = ARB_IDLE;
    endcase

    // grant_id deliberately keeps the last owner after release.
    if (release_pkt) begin
      active_n = 1'b0;
      rr_n     = rr_after;
      gap_n    = '0;
      state_n  = (GAP_CYCLES > 0) ? ARB_GAP : ARB_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      gid_q      <= '0;
      rr_q       <= '0;
      active_q   <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
      abort_q    <= 1'b0;
      last_q     <= 1'b0;
      hold_q     <= '0;
      gap_q      <= '0;
    end else begin
      state_q    <= state_n;
      gid_q      <= gid_n;
      rr_q       <= rr_n;
      active_q   <= active_n;
      tx_data_q  <= tx_data_n;
      tx_start_q <= tx_start_n;
      abort_q    <= abort_n;
      last_q     <= last_n;
      hold_q     <= hold_n;
      gap_q      <= gap_n;
    end
  end

  assign tx_data      = tx_data_q;
  assign tx_start     = tx_start_q;
  assign grant_id     = 3'(gid_q);
  assign grant_active = active_q;
  assign abort        = abort_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural uart_tx busy model
// and a scoreboard of {requester, byte} in expected transmission order.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int NR    = 4;
  localparam int GAP   = 5;
  localparam int HOLD  = 16;
  localparam int CPB   = 2;
  localparam int FRAME = UART_FRAME_BITS * CPB;

  logic            clk;
  logic            rst;
  logic [NR-1:0]   req_valid;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0]   req_last;
  logic [NR-1:0]   req_ready;
  logic [7:0]      tx_data;
  logic            tx_start;
  logic            tx_busy;
  logic [2:0]      grant_id;
  logic            grant_active;
  logic            abort;

  uart_tx_arbiter #(.N_REQ(NR), .GAP_CYCLES(GAP), .HOLD_TIMEOUT(HOLD)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .tx_data      (tx_data),
    .tx_start     (tx_start),
    .tx_busy      (tx_busy),
    .grant_id     (grant_id),
    .grant_active (grant_active),
    .abort        (abort)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [8:0]  srcq [NR][$];
  logic [10:0] sbq[$];
  logic [NR-1:0] pend;

  int grant_log[$];
  int gap_log[$];
  int rise_log[$];
  int start_log[$];
  int fall_cyc = 0;
  int busy_fall_cyc = 0;
  int abort_cnt = 0;
  int abort_delay = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_pkt(input int id, input int n, input logic [7:0] base, input bit with_last);
    logic [7:0] b;
    for (int k = 0; k < n; k++) begin
      b = base + 8'(k);
      srcq[id].push_back({with_last && (k == n - 1), b});
      sbq.push_back({3'(id), b});
    end
  endtask

  task automatic clear_logs();
    grant_log.delete();
    gap_log.delete();
    rise_log.delete();
    start_log.delete();
    abort_cnt = 0;
  endtask

  task automatic wait_quiet(input string tag, input int budget);
    bit quiet;
    int n;
    quiet = 1'b0;
    n = 0;
    while (!quiet && n < budget) begin
      step(1);
      n++;
      quiet = (sbq.size() == 0) && !grant_active && !tx_busy && !tx_start;
      for (int i = 0; i < NR; i++) if (srcq[i].size() != 0) quiet = 1'b0;
    end
    check(tag, 32'(quiet), 32'd1);
    step(8);
  endtask

  task automatic wait_grant(input int id, input int budget);
    bit got;
    int n;
    got = 1'b0;
    n = 0;
    while (!got && n < budget) begin
      step(1);
      n++;
      got = grant_active && (grant_id == 3'(id));
    end
    check("grant_wait", 32'(got), 32'd1);
  endtask

  // Requester sources: present the queue head, retire it once accepted.
  initial begin
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    pend      = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
        if (pend[i] && srcq[i].size() > 0) srcq[i].delete(0);
        if (srcq[i].size() > 0) begin
          req_valid[i]      = 1'b1;
          req_data[8*i +: 8] = srcq[i][0][7:0];
          req_last[i]       = srcq[i][0][8];
        end else begin
          req_valid[i]      = 1'b0;
          req_data[8*i +: 8] = 8'h00;
          req_last[i]       = 1'b0;
        end
      end
      #1;
      pend = req_ready & req_valid;
    end
  end

  // uart_tx model (busy one cycle after the start pulse, for FRAME cycles)
  // plus the output monitor.
  initial begin
    bit        start_seen;
    bit        prev_active;
    bit        prev_busy;
    int        busy_cnt;
    logic [10:0] exp;
    logic [NR-1:0] owner;
    tx_busy = 1'b0;
    start_seen = 1'b0;
    prev_active = 1'b0;
    prev_busy = 1'b0;
    busy_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rst) begin
        tx_busy = 1'b0;
        busy_cnt = 0;
        start_seen = 1'b0;
      end else begin
        if (tx_busy) begin
          busy_cnt--;
          if (busy_cnt == 0) tx_busy = 1'b0;
        end
        if (start_seen) begin
          tx_busy = 1'b1;
          busy_cnt = FRAME;
        end
        start_seen = tx_start;
      end
      if (prev_busy && !tx_busy) busy_fall_cyc = cyc;
      prev_busy = tx_busy;

      if (tx_start) begin
        check("start_while_busy", 32'(tx_busy), 32'd0);
        start_log.push_back(cyc);
        if (sbq.size() > 0) exp = sbq.pop_front();
        else                exp = 11'h7FF;
        check("tx_byte", 32'({grant_id, tx_data}), 32'(exp));
      end
      if (req_ready != '0) begin
        owner = NR'(1) << grant_id;
        check("ready_owner", 32'(req_ready), 32'(owner));
        check("ready_valid", 32'(req_ready & ~req_valid), 32'd0);
      end
      if (abort) begin
        abort_cnt++;
        abort_delay = cyc - busy_fall_cyc;
      end
      if (grant_active && !prev_active) begin
        grant_log.push_back(int'(grant_id));
        gap_log.push_back(cyc - fall_cyc);
        rise_log.push_back(cyc);
      end
      if (!grant_active && prev_active) fall_cyc = cyc;
      prev_active = grant_active;
    end
  end

  initial begin
    int push_cyc;
    bit seen;
    int n;
    rst = 1'b1;
    clear_logs();
    step(1);
    send_pkt(0, 3, 8'h41, 1'b1);
    step(2);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_grant_active", 32'(grant_active), 32'd0);
    check("rst_abort", 32'(abort), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);

    // Single requester, three-byte packet.
    rst = 1'b0;
    wait_quiet("t1_done", 1000);
    check("t1_ngrant", grant_log.size(), 1);
    check("t1_grant0", (grant_log.size() > 0) ? grant_log[0] : -1, 0);
    check("t1_nstart", start_log.size(), 3);
    if (start_log.size() == 3 && rise_log.size() > 0) begin
      check("t1_first_start", start_log[0] - rise_log[0], 1);
      check("t1_period01", start_log[1] - start_log[0], FRAME + 3);
      check("t1_period12", start_log[2] - start_log[1], FRAME + 3);
    end

    // Pointer now at 1: with 0 and 2 waiting, 2 must win first.
    clear_logs();
    push_cyc = cyc;
    send_pkt(2, 1, 8'h60, 1'b1);
    send_pkt(0, 2, 8'h50, 1'b1);
    wait_quiet("t1b_done", 1000);
    check("t1b_ngrant", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      check("t1b_grant0", grant_log[0], 2);
      check("t1b_grant1", grant_log[1], 0);
      check("t1b_req_to_grant", rise_log[0] - push_cyc, 1);
      check("t1b_gap", gap_log[1], GAP + 1);
    end

    // Reset while the first byte of a two-byte packet is on the line.
    clear_logs();
    send_pkt(3, 2, 8'h70, 1'b1);
    seen = 1'b0;
    n = 0;
    while (!seen && n < 200) begin
      step(1);
      n++;
      seen = tx_busy;
    end
    check("rst_busy_seen", 32'(seen), 32'd1);
    step(3);
    rst = 1'b1;
    srcq[3].delete();
    sbq.delete();
    step(1);
    check("midrst_tx_data", 32'(tx_data), 32'd0);
    check("midrst_tx_start", 32'(tx_start), 32'd0);
    check("midrst_grant_id", 32'(grant_id), 32'd0);
    check("midrst_grant_active", 32'(grant_active), 32'd0);
    check("midrst_abort", 32'(abort), 32'd0);
    rst = 1'b0;
    step(2);
    check("midrst_nstart", start_log.size(), 1);

    // Pointer back at 0: whole packet from 0, then whole packet from 2.
    clear_logs();
    send_pkt(0, 2, 8'h10, 1'b1);
    send_pkt(2, 2, 8'h20, 1'b1);
    wait_quiet("t2_done", 1000);
    check("t2_ngrant", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      check("t2_grant0", grant_log[0], 0);
      check("t2_grant1", grant_log[1], 2);
      check("t2_gap", gap_log[1], GAP + 1);
    end

    clear_logs();
    send_pkt(3, 1, 8'h30, 1'b1);
    wait_quiet("t2b_done", 500);
    check("t2b_grant0", (grant_log.size() > 0) ? grant_log[0] : -1, 3);

    // All four continuously requesting one-byte packets.
    clear_logs();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NR; i++) send_pkt(i, 1, 8'h80 + 8'(16 * r + i), 1'b1);
    wait_quiet("t3_done", 3000);
    check("t3_ngrant", grant_log.size(), 2 * NR);
    if (grant_log.size() == 2 * NR) begin
      for (int k = 0; k < 2 * NR; k++) begin
        check("t3_order", grant_log[k], k % NR);
        if (k > 0) check("t3_gap", gap_log[k], GAP + 1);
      end
    end

    // Owner stalls mid-packet; abort comes one cycle back in SEND plus HOLD
    // cycles after the line goes idle, then the next requester in turn wins.
    clear_logs();
    send_pkt(1, 2, 8'h90, 1'b0);
    wait_grant(1, 100);
    send_pkt(2, 1, 8'hA0, 1'b1);
    send_pkt(0, 1, 8'hB0, 1'b1);
    wait_quiet("t4_done", 2000);
    check("t4_abort_cnt", abort_cnt, 1);
    check("t4_abort_delay", abort_delay, HOLD + 1);
    check("t4_ngrant", grant_log.size(), 3);
    if (grant_log.size() == 3) begin
      check("t4_grant0", grant_log[0], 1);
      check("t4_grant1", grant_log[1], 2);
      check("t4_grant2", grant_log[2], 0);
      check("t4_gap", gap_log[1], GAP + 1);
    end

    check("sb_empty", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
